// File: rtl/number_display_driver.sv
// Purpose: shows a two's-complement number on a scanned decimal display. Each new
//   number goes through a serial binary-to-BCD conversion into a display buffer
//   with leading-zero blanking.
// Latency: for en_d high at edge k, busy is high from edge k to edge k+WIDTH+1, and the
//   buffer updates at edge k+WIDTH+1. disp_bcd/disp_sel follow one edge later.
// Backpressure: none. A strobe that arrives while busy is held in one pending slot,
//   and a later strobe overwrites it.
// Ports:
//   Clock     - single clock, rising edge
//   Reset     - synchronous, active-low
//   number_Q  - number register contents (two's complement, WIDTH bits)
//   number_EN - number register write strobe (number_Q is valid one edge later)
//   disp_sel  - one-hot digit select, bit 0 = least significant digit
//   disp_bcd  - BCD value of the selected digit, 4'hF = blank
//   disp_neg  - displayed value is negative
//   busy      - conversion in progress
module number_display_driver #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int SCAN_DIV = 1000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WIDTH-1:0]  number_Q,
  input  logic              number_EN,
  output logic [DIGITS-1:0] disp_sel,
  output logic [3:0]        disp_bcd,
  output logic              disp_neg,
  output logic              busy
);

  localparam int BW = DIGITS * 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

  state_e            state_q, state_d;
  logic              load, load_pend, set_pend, clr_pend;

  logic              en_dly_q;
  logic              pend_q;
  logic [WIDTH-1:0]  pend_val_q;
  logic              neg_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BW-1:0]     bcd_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     buf_q;
  logic              disp_neg_q;

  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [DIGITS-1:0] disp_sel_q;
  logic [3:0]        disp_bcd_q;

  logic [WIDTH-1:0]  load_val, load_mag;
  logic [BW-1:0]     bcd_adj, bcd_shift;
  logic [DIGITS-1:0] show;
  logic              seen_nz;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // A fresh strobe in COMMIT beats the pending slot. Either way the slot is
  // emptied because the newest value is the one being converted.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_pend = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_dly_q) begin
          load    = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        set_pend = en_dly_q;
        if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        if (en_dly_q) begin
          load     = 1'b1;
          clr_pend = 1'b1;
          state_d  = CONVERT;
        end else if (pend_q) begin
          load      = 1'b1;
          load_pend = 1'b1;
          clr_pend  = 1'b1;
          state_d   = CONVERT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != IDLE);
  end

  // ---------------- Conversion datapath ----------------
  // The magnitude is taken modulo 2^WIDTH, so the most negative value maps to
  // 2^(WIDTH-1) as an unsigned number.
  assign load_val = load_pend ? pend_val_q : number_Q;
  assign load_mag = load_val[WIDTH-1] ? (~load_val + WIDTH'(1)) : load_val;

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_shift = (bcd_adj << 1) | {{(BW-1){1'b0}}, bin_q[WIDTH-1]};
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      en_dly_q   <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      neg_q      <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      disp_neg_q <= 1'b0;
    end else begin
      // The number register updates on the strobe edge, so its new value is
      // valid one edge later.
      en_dly_q <= number_EN;

      if (clr_pend) begin
        pend_q <= 1'b0;
      end else if (set_pend) begin
        pend_q     <= 1'b1;
        pend_val_q <= number_Q;
      end

      if (load) begin
        neg_q <= load_val[WIDTH-1];
        bin_q <= load_mag;
        bcd_q <= '0;
        cnt_q <= '0;
      end else if (state_q == CONVERT) begin
        bcd_q <= bcd_shift;
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CW'(1);
      end

      // The buffer changes only here, so partial results are never displayed.
      if (state_q == COMMIT) begin
        buf_q      <= bcd_q;
        disp_neg_q <= neg_q;
      end
    end
  end

  // ---------------- Scanning ----------------
  // Show a digit if it, or any digit above it, is non-zero. Digit 0 is always shown.
  always_comb begin
    seen_nz = 1'b0;
    show    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen_nz = seen_nz | (buf_q[4*i +: 4] != 4'd0);
      show[i] = seen_nz || (i == 0);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      presc_q    <= '0;
      idx_q      <= '0;
      disp_sel_q <= DIGITS'(1);
      disp_bcd_q <= 4'd0;
    end else begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      // Select and digit value come from the same index, so they change together.
      disp_sel_q <= DIGITS'(1) << idx_q;
      disp_bcd_q <= show[idx_q] ? buf_q[{idx_q, 2'b00} +: 4] : 4'hF;
    end
  end

  assign disp_sel = disp_sel_q;
  assign disp_bcd = disp_bcd_q;
  assign disp_neg = disp_neg_q;

endmodule

// File: tb/tb_number_display_driver.sv
// Testbench for number_display_driver (WIDTH=32, DIGITS=10, SCAN_DIV=4).
// Expected displays are kept as 40-bit packed BCD, nibble i = position i, F = blank.
module tb_number_display_driver;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] number_Q = 32'd0;
  logic        number_EN = 1'b0;
  logic [9:0]  disp_sel;
  logic [3:0]  disp_bcd;
  logic        disp_neg;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [39:0] dig;
    logic        neg;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    logic [39:0] dig;
    logic        neg;
    string       tag;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  number_display_driver #(.WIDTH(32), .DIGITS(10), .SCAN_DIV(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .number_Q  (number_Q),
    .number_EN (number_EN),
    .disp_sel  (disp_sel),
    .disp_bcd  (disp_bcd),
    .disp_neg  (disp_neg),
    .busy      (busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic int sel_to_idx(input logic [9:0] sel);
    int r;
    r = 0;
    for (int i = 9; i >= 0; i--) if (sel[i]) r = i;
    return r;
  endfunction

  task automatic push_exp(input logic [39:0] dig, input logic neg);
    exp_t e;
    e.dig = dig;
    e.neg = neg;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    check("scoreboard not empty", (sb.size() != 0), 1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
  endtask

  // Strobe, then present the new value one edge later, as the number register does.
  task automatic strobe(input logic [31:0] v);
    @(negedge Clock);
    number_EN = 1'b1;
    @(negedge Clock);
    number_EN = 1'b0;
    number_Q  = v;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge Clock);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
  endtask

  // Watch one full scan rotation and compare every selected position.
  task automatic check_display(input logic [39:0] exp_dig, input logic exp_neg, input string tag);
    logic [9:0] seen;
    int idx;
    seen = '0;
    repeat (2) @(negedge Clock);
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      check({tag, " onehot"}, $onehot(disp_sel), 1);
      idx = sel_to_idx(disp_sel);
      check($sformatf("%s pos%0d", tag, idx), disp_bcd, exp_dig[4*idx +: 4]);
      check({tag, " neg"}, disp_neg, exp_neg);
      seen[idx] = 1'b1;
    end
    check({tag, " all positions"}, seen, 10'h3FF);
    check({tag, " busy idle"}, busy, 0);
  endtask

  initial begin
    exp_t e;
    int bc;
    int found;
    int negseen;
    int idx0;
    logic [9:0] prev;
    logic [9:0] one;

    vecs[0] = '{32'd12345,      40'hFFFFF12345, 1'b0, "v12345"};
    vecs[1] = '{32'h80000000,   40'h2147483648, 1'b1, "vmin"};
    vecs[2] = '{32'd0,          40'hFFFFFFFFF0, 1'b0, "vzero"};
    vecs[3] = '{32'hFFFFFFFF,   40'hFFFFFFFFF1, 1'b1, "vminus1"};
    vecs[4] = '{32'h7FFFFFFF,   40'h2147483647, 1'b0, "vmax"};
    vecs[5] = '{-32'sd12345,    40'hFFFFF12345, 1'b1, "vminus12345"};
    vecs[6] = '{32'd1000000000, 40'h1000000000, 1'b0, "v1e9"};
    vecs[7] = '{32'd100,        40'hFFFFFFF100, 1'b0, "v100"};

    // Scenario 1: reset values, then a blank display showing "0".
    repeat (3) @(negedge Clock);
    check("reset busy", busy, 0);
    check("reset sel", disp_sel, 10'h001);
    check("reset bcd", disp_bcd, 0);
    check("reset neg", disp_neg, 0);
    Reset = 1'b1;
    check_display(40'hFFFFFFFFF0, 1'b0, "s1 reset display");

    // Table-driven conversions (scenarios 2 and 3 included).
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].dig, vecs[i].neg);
      strobe(vecs[i].val);
      count_busy(bc);
      check({vecs[i].tag, " busy cycles"}, bc, 33);
      pop_exp(e);
      check_display(e.dig, e.neg, vecs[i].tag);
    end

    // Scenario 4: 7, then -9 and 3 while busy. 3 overwrites -9 and is converted
    // right after 7 commits. Align to the start of the position-0 window so that
    // position 0 is selected while 3 is being converted.
    found = 0;
    prev  = disp_sel;
    for (int n = 0; n < 100; n++) begin
      @(negedge Clock);
      if (disp_sel == 10'h001 && prev == 10'h200) begin
        found = 1;
        break;
      end
      prev = disp_sel;
    end
    check("s4 align", found, 1);
    number_EN = 1'b1;
    push_exp(40'hFFFFFFFFF7, 1'b0);
    bc = 0;
    negseen = 0;
    for (int rel = 1; rel <= 75; rel++) begin
      @(negedge Clock);
      if (busy) bc++;
      if (disp_neg) negseen = 1;
      if (rel == 41) begin
        pop_exp(e);
        check("s4 sel pos0 during reconvert", disp_sel, 10'h001);
        check("s4 held 7 during reconvert", disp_bcd, e.dig[3:0]);
      end
      case (rel)
        1:  begin number_EN = 1'b0; number_Q = 32'd7; end
        5:  number_EN = 1'b1;
        6:  begin number_EN = 1'b0; number_Q = 32'hFFFFFFF7; end
        13: number_EN = 1'b1;
        14: begin number_EN = 1'b0; number_Q = 32'd3; push_exp(40'hFFFFFFFFF3, 1'b0); end
        default: ;
      endcase
    end
    check("s4 busy back-to-back cycles", bc, 66);
    check("s4 negative never shown", negseen, 0);
    pop_exp(e);
    check_display(e.dig, e.neg, "s4 final");

    // Scenario 5: reset in cycle 10 of a conversion of 99 aborts it.
    @(negedge Clock);
    number_EN = 1'b1;
    @(negedge Clock);
    number_EN = 1'b0;
    number_Q  = 32'd99;
    repeat (10) @(negedge Clock);
    check("s5 busy before reset", busy, 1);
    Reset = 1'b0;
    @(negedge Clock);
    check("s5 reset busy", busy, 0);
    check("s5 reset sel", disp_sel, 10'h001);
    check("s5 reset bcd", disp_bcd, 0);
    check("s5 reset neg", disp_neg, 0);
    Reset = 1'b1;
    push_exp(40'hFFFFFFFFF0, 1'b0);
    pop_exp(e);
    check_display(e.dig, e.neg, "s5 after reset");

    // Scenario 6: the select advances every 4 cycles and wraps from bit 9 to bit 0.
    found = 0;
    prev  = disp_sel;
    idx0  = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge Clock);
      if (disp_sel != prev) begin
        found = 1;
        idx0  = sel_to_idx(disp_sel);
        break;
      end
      prev = disp_sel;
    end
    check("s6 select changes", found, 1);
    one = 10'd1;
    for (int n = 1; n < 44; n++) begin
      @(negedge Clock);
      check($sformatf("s6 sel step %0d", n), disp_sel, one << ((idx0 + n / 4) % 10));
      check($sformatf("s6 bcd step %0d", n), disp_bcd, (((idx0 + n / 4) % 10) == 0) ? 4'h0 : 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/number_display_driver.md
NUMBER_DISPLAY_DRIVER -- requirements
Module: number_display_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the width of the data word held in the number register.
REQ-002 The block SHALL have parameter DIGITS, default 10, the number of decimal display positions; DIGITS SHALL be at least ceil(WIDTH*log10(2)).
REQ-003 The block SHALL have parameter SCAN_DIV, default 1000, the number of clock cycles each digit stays selected during scanning.
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port number_Q, input, WIDTH bits: the current number register contents, two's complement.
REQ-007 The block SHALL have port number_EN, input, 1 bit: the number register write strobe; it indicates that number_Q changes at this edge.
REQ-008 The block SHALL have port disp_sel, output, DIGITS bits: one-hot enable of the digit being shown; bit 0 is the least significant digit.
REQ-009 The block SHALL have port disp_bcd, output, 4 bits: the BCD value of the selected digit; 4'hF means blank.
REQ-010 The block SHALL have port disp_neg, output, 1 bit: the displayed value is negative.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-012 The block SHALL be controlled by a state machine with the states IDLE, CONVERT and COMMIT.
REQ-013 The block SHALL treat the number_Q value sampled one edge after number_EN is high as the new value, because the register updates on the same edge as the strobe.
- Implementation: register number_EN for one cycle (en_d) and sample number_Q when en_d is high.
REQ-014 In IDLE, when en_d is high, the block SHALL capture neg = number_Q[WIDTH-1] and an unsigned WIDTH-bit magnitude mag = |number_Q|, then enter CONVERT.
- -2^(WIDTH-1) SHALL yield mag = 2^(WIDTH-1) with no overflow.
REQ-015 CONVERT SHALL perform shift-add-3 (double-dabble) binary-to-BCD conversion, one bit per cycle, for exactly WIDTH cycles, into a DIGITS*4-bit working register; the block SHALL then enter COMMIT.
REQ-016 COMMIT SHALL last one cycle: the working BCD and neg SHALL be copied into the display buffer, and disp_neg SHALL update at that edge.
REQ-017 The display buffer SHALL hold its old value throughout CONVERT, so the display never shows partial results.
REQ-018 The busy output SHALL be high in CONVERT and COMMIT and low in IDLE.
REQ-019 Latency: for en_d high at edge k, busy SHALL be high from edge k to k+WIDTH+1, and the new value SHALL be visible after edge k+WIDTH+1.
REQ-020 If en_d is high while the state is CONVERT or COMMIT, the block SHALL store number_Q in a single pending slot and set a pending flag.
- A later en_d SHALL overwrite the pending slot (last value wins).
REQ-021 On leaving COMMIT with pending set, the block SHALL enter CONVERT with the pending value and clear pending; otherwise it SHALL enter IDLE.
- If en_d and pending occur in the same COMMIT cycle, the en_d value SHALL be the one used.
REQ-022 Scan prescaler: a counter SHALL count 0..SCAN_DIV-1 and wrap; when it wraps, the digit index SHALL advance by one, wrapping from DIGITS-1 to 0.
- Scanning SHALL run in every state.
REQ-023 disp_sel SHALL be one-hot at the current digit index; disp_sel and disp_bcd SHALL be registered and change together.
REQ-024 Leading-zero blanking: disp_bcd SHALL be 4'hF for every position above the most significant non-zero digit of the buffer; position 0 SHALL always show its digit, so a value of 0 displays "0".

Reset
REQ-025 While Reset is low at a clock edge, the block SHALL set:
- state to IDLE, with en_d, pending, the pending slot, the working register, the buffer and the prescaler all 0;
- the digit index to 0 and disp_sel to one-hot bit 0;
- disp_bcd, disp_neg and busy to 0.
REQ-026 Reset SHALL take priority over all other events and SHALL abort a conversion without updating the buffer.

Verification
REQ-027 The bench SHALL cover scenario 1: reset, then scan for one full rotation -> position 0 shows 0, positions 1-9 show F, disp_neg=0, busy=0.
REQ-028 The bench SHALL cover scenario 2: strobe number_EN with the value becoming 12345 -> busy high for 33 cycles, then positions 0-4 show 5,4,3,2,1, positions 5-9 show F, disp_neg=0.
REQ-029 The bench SHALL cover scenario 3: the value becomes 32'h80000000 -> positions 0-9 show 8,4,6,3,8,4,7,4,1,2, disp_neg=1.
REQ-030 The bench SHALL cover scenario 4: value 7, then value -9 strobed 5 cycles later and value 3 strobed 8 cycles later -> 7 is committed, then 3 is converted immediately (-9 is dropped), final display 3 with disp_neg=0.
REQ-031 The bench SHALL cover scenario 5: Reset low during cycle 10 of the conversion of 99 -> next edge gives reset values, display shows 0, busy=0.
REQ-032 The bench SHALL cover scenario 6: SCAN_DIV=4 -> disp_sel advances every 4 cycles, wraps from bit 9 to bit 0 after 40 cycles, and disp_bcd always matches the selected position.
